// File: rtl/pipe_pkg.sv
// Shared definitions for the round-robin scheduled arithmetic pipeline:
// default operand/result widths, the tag width helper and a stage record type.
package pipe_pkg;

  localparam int IW_DEF = 3;
  localparam int OW_DEF = 6;

  // Width of a requester index; at least one bit so a single requester still has a tag.
  function automatic int tag_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int TW_DEF = 1;

  // Stage record at the default widths. In S1 the operand slots hold a, b, c;
  // from S2 on, s carries the zero-extended sum a + b.
  typedef struct packed {
    logic              valid;
    logic [TW_DEF-1:0] tag;
    logic [IW_DEF-1:0] a;
    logic [IW_DEF-1:0] b;
    logic [IW_DEF-1:0] c;
    logic [IW_DEF:0]   s;
  } pipe_stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among NREQ requesters, scanning from the
// slot after the last granted one. The pointer only moves on a real grant, so
// idle or disabled cycles leave the rotation untouched.
module rr_arbiter
  import pipe_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int TW   = tag_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [TW-1:0]   grant_idx_o,
  output logic            grant_valid_o
);

  logic [TW-1:0] last_q;
  logic [TW-1:0] last_d;
  logic [TW-1:0] cand;

  // Scan candidates last+1 .. last+NREQ (mod NREQ); first pending one wins while enabled.
  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    cand          = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = TW'((int'(last_q) + k) % NREQ);
      if (en_i && !grant_valid_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
        grant_valid_o = 1'b1;
      end
    end
  end

  // Pointer follows accepted grants only.
  always_comb begin
    last_d = last_q;
    if (grant_valid_o) last_d = grant_idx_o;
  end

  // Pointer register; reset to NREQ-1 so requester 0 is first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= TW'(NREQ - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/pipe_rr_scheduler.sv
// Round-robin scheduler in front of a 3-stage arithmetic pipeline:
// S1 registers the granted operand triple, S2 forms s = a + b, S3 forms
// r = s*c + c (mod 2^OW) and presents it with the issuing requester's tag.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; ready never depends on the same requester holding valid longer, a
// requester must keep valid and its operands stable until it sees ready, and the
// result side holds res_data/res_tag stable while res_valid && !res_ready.
module pipe_rr_scheduler
  import pipe_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int IW   = IW_DEF,
  parameter  int OW   = OW_DEF,
  localparam int TW   = tag_w(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*IW-1:0] req_a,
  input  logic [NREQ*IW-1:0] req_b,
  input  logic [NREQ*IW-1:0] req_c,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [OW-1:0]      res_data,
  output logic [TW-1:0]      res_tag,
  output logic [1:0]         in_flight,
  output logic               busy
);

  // Stage records sized by this instance's parameters.
  typedef struct packed {
    logic          valid;
    logic [TW-1:0] tag;
    logic [IW-1:0] a;
    logic [IW-1:0] b;
    logic [IW-1:0] c;
  } s1_t;

  typedef struct packed {
    logic          valid;
    logic [TW-1:0] tag;
    logic [IW:0]   s;
    logic [IW-1:0] c;
  } s2_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  logic          res_valid_q, res_valid_d;
  logic [OW-1:0] res_data_q, res_data_d;
  logic [TW-1:0] res_tag_q, res_tag_d;
  logic [1:0]    in_flight_q, in_flight_d;

  logic            advance;
  logic [NREQ-1:0] grant;
  logic [TW-1:0]   grant_idx;
  logic            grant_valid;
  logic [IW-1:0]   a_sel, b_sel, c_sel;
  logic [OW-1:0]   s_ext, c_ext, mac;

  // Whole pipe moves together unless the output holds an unconsumed result.
  assign advance = !res_valid_q || res_ready;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_valid),
    .en_i         (advance && !rst),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .grant_valid_o(grant_valid)
  );

  // The arbiter only grants while the pipe can advance, so grant is already ready.
  assign req_ready = grant;

  // Operand mux for the granted requester.
  always_comb begin
    a_sel = req_a[int'(grant_idx)*IW +: IW];
    b_sel = req_b[int'(grant_idx)*IW +: IW];
    c_sel = req_c[int'(grant_idx)*IW +: IW];
  end

  // Multiply-accumulate of S3, folded as s*c + c and truncated to OW bits.
  always_comb begin
    s_ext = OW'(s2_q.s);
    c_ext = OW'(s2_q.c);
    mac   = s_ext * c_ext + c_ext;
  end

  // Next-state of all stages: shift on advance (idle slots enter as bubbles), else hold.
  always_comb begin
    s1_d        = s1_q;
    s2_d        = s2_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    if (advance) begin
      s1_d.valid = grant_valid;
      s1_d.tag   = grant_idx;
      if (grant_valid) begin
        s1_d.a = a_sel;
        s1_d.b = b_sel;
        s1_d.c = c_sel;
      end
      s2_d.valid  = s1_q.valid;
      s2_d.tag    = s1_q.tag;
      s2_d.s      = {1'b0, s1_q.a} + {1'b0, s1_q.b};
      s2_d.c      = s1_q.c;
      res_valid_d = s2_q.valid;
      res_tag_d   = s2_q.tag;
      res_data_d  = mac;
    end
    in_flight_d = {1'b0, s1_d.valid} + {1'b0, s2_d.valid} + {1'b0, res_valid_d};
  end

  // Stage registers; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      in_flight_q <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign in_flight = in_flight_q;
  assign busy      = (in_flight_q != 2'd0);

endmodule
